spi_master: RTL and testbench

SPI_MASTER -- requirements
Module: spi_master

---
 rtl/spi_master.sv | 161 ++++++++++++++++
 tb/tb_spi_master.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI master, mode 0 (CPOL=0, CPHA=0), MSB first on both lines.
//
// Each frame: LEAD (ss low, sclk low), FRAME sclk pulses made of HIGH/LOW half-periods,
// TRAIL (sclk low), then GAP (ss high, still busy) before returning to IDLE. Every non-idle
// state lasts CLKDIV clk cycles. FRAME = max(TXWIDTH, RXWIDTH); missing TX bits go out as 0 and
// extra RX samples beyond RXWIDTH are dropped (the first RXWIDTH samples are kept).
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   tx_buffer  word to send, captured when wr is accepted in IDLE
//   wr         start-frame request, level-sampled, only honoured in IDLE
//   sclk       SPI clock
//   mosi       serial data out
//   miso       serial data in, sampled on the last clk cycle of each sclk high phase
//   ss         slave select, active low
//   rx_buffer  last completely received word
//   rx_dv      one-cycle pulse when rx_buffer is updated
//   busy       high from frame acceptance until the end of the inter-frame gap
module spi_master #(
    parameter int unsigned TXWIDTH = 4,
    parameter int unsigned RXWIDTH = 4,
    parameter int unsigned CLKDIV  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [TXWIDTH-1:0] tx_buffer,
    input  logic               wr,
    output logic               sclk,
    output logic               mosi,
    input  logic               miso,
    output logic               ss,
    output logic [RXWIDTH-1:0] rx_buffer,
    output logic               rx_dv,
    output logic               busy
);

    localparam int unsigned FRAME = (TXWIDTH > RXWIDTH) ? TXWIDTH : RXWIDTH;
    localparam int unsigned DivW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned BitW  = (FRAME > 1) ? $clog2(FRAME) : 1;

    localparam logic [DivW-1:0] DivLast = DivW'(CLKDIV - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(FRAME - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StHigh,
        StLow,
        StTrail,
        StGap
    } state_e;

    state_e               state_q, state_d;
    logic [DivW-1:0]      div_q, div_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [TXWIDTH-1:0]   tx_q, tx_d;
    logic [FRAME-1:0]     rx_sh_q, rx_sh_d;
    logic [RXWIDTH-1:0]   rx_buf_q, rx_buf_d;
    logic                 rx_dv_q, rx_dv_d;
    logic                 div_done;

    // Final cycle of the current CLKDIV-long state.
    assign div_done = (div_q == DivLast);

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_sh_d  = rx_sh_q;
        rx_buf_d = rx_buf_q;
        rx_dv_d  = 1'b0;

        // The divider free-runs in every non-idle state and wraps at each state boundary,
        // so it is back at 0 whenever IDLE is entered.
        if (state_q != StIdle) begin
            div_d = div_done ? '0 : div_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (wr) begin
                    state_d = StLead;
                    tx_d    = tx_buffer;
                    rx_sh_d = '0;
                    bit_d   = '0;
                    div_d   = '0;
                end
            end
            StLead: begin
                if (div_done) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (div_done) begin
                    rx_sh_d = (rx_sh_q << 1) | FRAME'(miso);
                    if (bit_q == BitLast) begin
                        state_d = StTrail;
                    end else begin
                        state_d = StLow;
                        bit_d   = bit_q + 1'b1;
                        // Zero fill makes mosi 0 once the TX bits run out.
                        tx_d    = tx_q << 1;
                    end
                end
            end
            StLow: begin
                if (div_done) begin
                    state_d = StHigh;
                end
            end
            StTrail: begin
                if (div_done) begin
                    state_d  = StGap;
                    rx_dv_d  = 1'b1;
                    // First-sampled bit sits at the top of the shift register.
                    rx_buf_d = rx_sh_q[FRAME-1 -: RXWIDTH];
                end
            end
            StGap: begin
                if (div_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            div_q    <= '0;
            bit_q    <= '0;
            tx_q     <= '0;
            rx_sh_q  <= '0;
            rx_buf_q <= '0;
            rx_dv_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_sh_q  <= rx_sh_d;
            rx_buf_q <= rx_buf_d;
            rx_dv_q  <= rx_dv_d;
        end
    end

    // Outputs decode straight from registered state, so they are glitch-free per state.
    assign ss        = (state_q == StIdle) || (state_q == StGap);
    assign sclk      = (state_q == StHigh);
    assign busy      = (state_q != StIdle);
    assign mosi      = ~ss & tx_q[TXWIDTH-1];
    assign rx_buffer = rx_buf_q;
    assign rx_dv     = rx_dv_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master. Four configurations run in parallel, each with its own
// cycle-level reference model that derives the expected pins from the cycle offset since frame
// acceptance (phase = (k-1)/CLKDIV: 0 lead, odd high, even low, 2*FRAME trail, then gap).
//   g0: TX=4 RX=4 CLKDIV=2  loopback, busy rejection, mid-frame reset
//   g1: TX=2 RX=4 CLKDIV=1  width mismatch with a mode-0 slave returning 0110
//   g2: TX=4 RX=4 CLKDIV=1  rst/wr collision, continuous wr
//   g3: TX=4 RX=2 CLKDIV=3  random only (extra samples dropped)
module tb_spi_master;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_cfg
        localparam int TXW = (g == 1) ? 2 : 4;
        localparam int RXW = (g == 3) ? 2 : 4;
        localparam int CD  = (g == 0) ? 2 : ((g == 3) ? 3 : 1);
        localparam int FR  = (TXW > RXW) ? TXW : RXW;
        localparam int LEN = CD * (2 + 2 * FR);

        logic           rst = 1'b0;
        logic           wr = 1'b0;
        logic           loop = 1'b0;
        logic           slave_en = 1'b0;
        logic           rnd_bit = 1'b0;
        logic [TXW-1:0] tx = '0;
        bit             en = 1'b0;
        bit             done = 1'b0;

        logic           sclk, mosi, miso, ss, rx_dv, busy;
        logic [RXW-1:0] rx_buffer;
        logic           slave_bit = 1'b0;
        logic           miso_src;

        assign miso_src = slave_en ? slave_bit : rnd_bit;
        assign miso     = loop ? mosi : miso_src;

        spi_master #(
            .TXWIDTH(TXW),
            .RXWIDTH(RXW),
            .CLKDIV (CD)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_buffer(tx),
            .wr       (wr),
            .sclk     (sclk),
            .mosi     (mosi),
            .miso     (miso),
            .ss       (ss),
            .rx_buffer(rx_buffer),
            .rx_dv    (rx_dv),
            .busy     (busy)
        );

        // Mode-0 slave: first bit valid once ss falls, next bit after each sclk falling edge.
        logic [3:0] slave_word = 4'b0110;
        int         s_idx = 0;
        logic       s_prev = 1'b0;
        initial forever begin
            @(negedge clk);
            if (ss) s_idx = 0;
            else if (s_prev && !sclk) s_idx++;
            s_prev    = sclk;
            slave_bit = (s_idx < 4) ? slave_word[3 - s_idx] : 1'b0;
        end

        // Reference model.
        bit             m_act = 1'b0;
        int             m_k = 0;
        int             m_p, m_b;
        logic [TXW-1:0] m_tx = '0;
        logic [FR-1:0]  m_sh = '0;
        logic [RXW-1:0] m_rx = '0;
        logic           e_dv = 1'b0, e_ss = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_busy = 1'b0;

        initial forever begin
            @(posedge clk);
            if (rst) begin
                m_act = 1'b0;
                m_k   = 0;
                m_rx  = '0;
                e_dv  = 1'b0;
            end else if (!m_act) begin
                e_dv = 1'b0;
                if (wr) begin
                    m_act = 1'b1;
                    m_k   = 1;
                    m_tx  = tx;
                    m_sh  = '0;
                end
            end else begin
                m_p = (m_k - 1) / CD;
                if (m_p % 2 == 1 && m_p < 2 * FR && (m_k - 1) % CD == CD - 1)
                    m_sh = {m_sh[FR-2:0], (loop ? e_mosi : miso_src)};
                m_k++;
                e_dv = (m_k == 1 + CD * (1 + 2 * FR));
                if (e_dv) m_rx = m_sh[FR-1 -: RXW];
                if (m_k > LEN) m_act = 1'b0;
            end
            if (!m_act) begin
                e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_busy = 1'b0;
            end else begin
                m_p    = (m_k - 1) / CD;
                e_busy = 1'b1;
                if (m_p <= 2 * FR) begin
                    e_ss   = 1'b0;
                    e_sclk = (m_p % 2 == 1);
                    m_b    = (m_p == 2 * FR) ? FR - 1 : m_p / 2;
                    e_mosi = (m_b < TXW) ? m_tx[TXW-1-m_b] : 1'b0;
                end else begin
                    e_ss = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0;
                end
            end
        end

        // Compare process: every cycle once out of the first reset.
        initial forever begin
            @(negedge clk);
            if (en) begin
                chk($sformatf("g%0d ss", g), ss, e_ss);
                chk($sformatf("g%0d sclk", g), sclk, e_sclk);
                chk($sformatf("g%0d mosi", g), mosi, e_mosi);
                chk($sformatf("g%0d busy", g), busy, e_busy);
                chk($sformatf("g%0d rx_dv", g), rx_dv, e_dv);
                chk($sformatf("g%0d rx_buffer", g), rx_buffer, m_rx);
            end
        end

        task automatic do_reset();
            rst = 1'b1;
            wr  = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            en  = 1'b1;
        endtask

        task automatic rand_phase(input int n);
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                rst     = ($urandom_range(0, 299) == 0);
                wr      = ($urandom_range(0, 3) == 0);
                tx      = TXW'($urandom);
                rnd_bit = 1'($urandom);
                if ($urandom_range(0, 63) == 0) loop = 1'($urandom);
            end
            @(negedge clk);
            rst = 1'b0;
            wr  = 1'b0;
        endtask

        if (g == 0) begin : g_stim
            initial begin
                int   rises, highs, dvs;
                logic prev;
                do_reset();
                // Loopback 1010; wr retried while busy; tx scrambled after acceptance.
                loop = 1'b1; tx = 4'b1010; wr = 1'b1;
                rises = 0; highs = 0; dvs = 0; prev = 1'b0;
                for (int c = 1; c <= 24; c++) begin
                    @(negedge clk);
                    wr = (c == 5 || c == 19);
                    tx = TXW'($urandom);
                    if (sclk && !prev) rises++;
                    if (sclk) highs++;
                    if (rx_dv) dvs++;
                    prev = sclk;
                    if (c == 1) chk("g0 ss low at T+1", ss, 0);
                    if (c == 18) chk("g0 ss low at T+18", ss, 0);
                    if (c == 19) begin
                        chk("g0 ss high at T+19", ss, 1);
                        chk("g0 rx_dv at T+19", rx_dv, 1);
                        chk("g0 rx_buffer loopback", rx_buffer, 4'b1010);
                        chk("g0 model rx loopback", m_rx, 4'b1010);
                        chk("g0 model dv at T+19", e_dv, 1);
                    end
                    if (c == 20) begin
                        chk("g0 busy at T+20", busy, 1);
                        chk("g0 rx_dv single pulse", rx_dv, 0);
                    end
                    if (c == 21) chk("g0 busy low at T+21", busy, 0);
                    if (c == 24) chk("g0 no second frame", ss, 1);
                end
                wr = 1'b0;
                chk("g0 sclk pulses", rises, 4);
                chk("g0 sclk high cycles", highs, 8);
                chk("g0 rx_dv count", dvs, 1);

                // Reset during the second HIGH phase.
                repeat (3) @(negedge clk);
                tx = TXW'($urandom); wr = 1'b1; dvs = 0;
                for (int c = 1; c <= 30; c++) begin
                    @(negedge clk);
                    wr = 1'b0;
                    if (rx_dv) dvs++;
                    if (c == 7) begin
                        chk("g0 in second high", sclk, 1);
                        rst = 1'b1;
                    end
                    if (c == 8) begin
                        rst = 1'b0;
                        chk("g0 abort ss", ss, 1);
                        chk("g0 abort sclk", sclk, 0);
                        chk("g0 abort busy", busy, 0);
                        chk("g0 abort rx_buffer", rx_buffer, 0);
                    end
                end
                chk("g0 no rx_dv after abort", dvs, 0);

                tx = 4'b0101; wr = 1'b1;
                for (int c = 1; c <= 21; c++) begin
                    @(negedge clk);
                    wr = 1'b0;
                    tx = TXW'($urandom);
                    if (c == 19) begin
                        chk("g0 post-reset rx_dv", rx_dv, 1);
                        chk("g0 post-reset rx_buffer", rx_buffer, 4'b0101);
                    end
                end
                rand_phase(1500);
                done = 1'b1;
            end
        end else if (g == 1) begin : g_stim
            initial begin
                int         rises;
                logic       prev;
                logic [3:0] seq;
                do_reset();
                slave_en = 1'b1; loop = 1'b0; tx = 2'b11; wr = 1'b1;
                rises = 0; prev = 1'b0; seq = '0;
                for (int c = 1; c <= 14; c++) begin
                    @(negedge clk);
                    wr = 1'b0;
                    tx = TXW'($urandom);
                    if (sclk && !prev) begin
                        rises++;
                        seq = {seq[2:0], mosi};
                    end
                    prev = sclk;
                    if (c == 10) begin
                        chk("g1 rx_dv at T+10", rx_dv, 1);
                        chk("g1 rx_buffer from slave", rx_buffer, 4'b0110);
                        chk("g1 model rx from slave", m_rx, 4'b0110);
                    end
                end
                chk("g1 sclk pulses", rises, 4);
                chk("g1 mosi sequence", seq, 4'b1100);
                slave_en = 1'b0;
                rand_phase(1500);
                done = 1'b1;
            end
        end else if (g == 2) begin : g_stim
            initial begin
                int   falls, dvs, run;
                logic prev_ss;
                do_reset();
                // rst and wr together: no frame.
                rst = 1'b1; wr = 1'b1;
                @(negedge clk);
                rst = 1'b0; wr = 1'b0;
                chk("g2 collision ss", ss, 1);
                chk("g2 collision busy", busy, 0);
                @(negedge clk);
                chk("g2 collision ss stays", ss, 1);

                // wr held high for 60 cycles: accepts at offsets 0,11,..,55.
                loop = 1'b1; wr = 1'b1; tx = TXW'($urandom);
                falls = 0; dvs = 0; run = 0; prev_ss = 1'b1;
                for (int c = 1; c <= 75; c++) begin
                    @(negedge clk);
                    if (c == 60) wr = 1'b0;
                    tx = TXW'($urandom);
                    if (rx_dv) dvs++;
                    if (c == 10) chk("g2 first rx_dv at T+10", rx_dv, 1);
                    if (!ss && prev_ss) begin
                        falls++;
                        if (falls > 1) chk("g2 ss high between frames", run, 2);
                    end
                    run     = ss ? run + 1 : 0;
                    prev_ss = ss;
                end
                chk("g2 frames started", falls, 6);
                chk("g2 rx_dv pulses", dvs, 6);
                rand_phase(1500);
                done = 1'b1;
            end
        end else begin : g_stim
            initial begin
                do_reset();
                rand_phase(1500);
                done = 1'b1;
            end
        end
    end

    initial begin
        int waited;
        waited = 0;
        while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done && g_cfg[3].done)
               && waited < 20000) begin
            @(negedge clk);
            waited++;
        end
        chk("all stimulus complete in time", (waited < 20000), 1);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
